// File: rtl/alu_hilo_sequencer.sv
// Sequences the multi-cycle unsigned divider and the HI/LO commit behind the EX-stage ALU.
// It also drives the HI/LO interlock stall and the ALU output-mux select.
module alu_hilo_sequencer #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [5:0]  funct,
    input  logic        abort,
    output logic        div_start,
    output logic        hilo_we,
    output logic        busy,
    output logic        stall,
    output logic [1:0]  alu_sel,
    output logic [15:0] div_count
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_MFHI = 6'd16;
    localparam logic [5:0] FN_MFLO = 6'd18;
    localparam logic [5:0] FN_DIVU = 6'd27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             hilo_dep;

    assign hilo_dep = (funct == FN_DIVU) || (funct == FN_MFHI) || (funct == FN_MFLO);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            div_start <= 1'b0;
            div_count <= '0;
        end else begin
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid && (funct == FN_DIVU) && !abort) begin
                        state     <= RUN;
                        cnt       <= CNT_W'(DIV_CYCLES - 1);
                        div_start <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                    if (!abort && (div_count != 16'hFFFF))
                        div_count <= div_count + 16'd1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // A flush landing on the DONE cycle must not commit a result HI/LO consumers were told to discard.
    assign hilo_we = (state == DONE) && !abort;
    assign busy    = (state != IDLE);

    // HI/LO consumers wait through DONE because the register file is written at the end of that cycle.
    assign stall = !reset && op_valid && busy && hilo_dep;

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        alu_sel = 2'd0;
        if (!reset && op_valid) begin
            case (funct)
                FN_MFHI:        alu_sel = 2'd1;
                FN_MFLO:        alu_sel = 2'd2;
                FN_SLL, FN_SRL: alu_sel = 2'd3;
                default:        alu_sel = 2'd0;
            endcase
        end
    end

endmodule
